// File: rtl/referee_2_if.sv
// Egress arbiter bus: four source FIFO read ports on one side, one downstream
// write port on the other, plus the arbiter's grant/idle status.
interface referee_2_if #(
    parameter int LINE_SIZE = 12
);
    logic [3:0]             empty_f_signal;
    logic [4*LINE_SIZE-1:0] data_out;
    logic                   almost_full_out;
    logic                   full_out;
    logic [3:0]             pop_signal;
    logic                   push_out;
    logic [LINE_SIZE-1:0]   data_in;
    logic [1:0]             grant;
    logic                   idle;

    modport slave (
        input  empty_f_signal, data_out, almost_full_out, full_out,
        output pop_signal, push_out, data_in, grant, idle
    );

    modport master (
        output empty_f_signal, data_out, almost_full_out, full_out,
        input  pop_signal, push_out, data_in, grant, idle
    );
endinterface

// File: rtl/referee_2.sv
// Egress referee: drains four per-class FIFOs into one downstream FIFO, one line per cycle.
// Build option STRICT_PRIORITY_EN selects fixed priority (0 highest) instead of round-robin.
module referee_2 #(
    parameter int LINE_SIZE = 12
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic [3:0]  state,
    referee_2_if.slave  bus
);
    localparam int NUM_SRC = 4;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    logic [3:0]           pop_q;
    logic                 push_q;
    logic [LINE_SIZE-1:0] data_q;
    logic [1:0]           grant_q;
    logic                 idle_q;
    logic                 inflight;
    logic [1:0]           sel;
    logic                 found;
    logic                 can_pop;

`ifdef STRICT_PRIORITY_EN
    // Descending scan so the lowest non-empty index is written last and wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!bus.empty_f_signal[i]) begin
                sel   = 2'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic [1:0] rr;
    logic [1:0] idx;

    // Scan offsets 3..0 from rr; the smallest offset to a non-empty source wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = rr + 2'(i);
            if (!bus.empty_f_signal[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L)
            rr <= '0;
        else if (can_pop)
            rr <= sel + 2'd1;
    end
`endif

    assign can_pop = (state == ST_ACTIVE) && !bus.almost_full_out && !bus.full_out && found;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pop_q    <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            grant_q  <= '0;
            idle_q   <= 1'b1;
            inflight <= 1'b0;
        end else begin
            pop_q    <= can_pop ? (4'b0001 << sel) : 4'b0000;
            inflight <= can_pop;
            if (can_pop)
                grant_q <= sel;
            // A line popped last cycle is pushed regardless of throttle or state.
            push_q <= inflight;
            if (inflight)
                data_q <= bus.data_out[grant_q*LINE_SIZE +: LINE_SIZE];
            idle_q <= (&bus.empty_f_signal) && !inflight;
        end
    end

    assign bus.pop_signal = pop_q;
    assign bus.push_out   = push_q;
    assign bus.data_in    = data_q;
    assign bus.grant      = grant_q;
    assign bus.idle       = idle_q;
endmodule

// File: tb/tb_referee_2.sv
// Scoreboard bench for referee_2: directed phases push expected pops/lines,
// a monitor pops and compares whenever the DUT pops or pushes.
module tb_referee_2;
    localparam int LS = 12;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] state = 4'b0001;

    referee_2_if #(.LINE_SIZE(LS)) bus ();
    referee_2 #(.LINE_SIZE(LS)) dut (.clk(clk), .reset_L(reset_L), .state(state), .bus(bus));

    always #5 clk = ~clk;

    // Source FIFO model: FIFO i shows 12'h100*i + k, k = pops taken so far.
    logic [7:0] cnt [4] = '{default: 8'd0};
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (bus.pop_signal[i]) cnt[i] <= cnt[i] + 8'd1;

    for (genvar g = 0; g < 4; g++) begin : g_src
        assign bus.data_out[g*LS +: LS] = LS'(g * 256) + LS'(cnt[g]);
    end

    logic [3:0]  exp_pop [$];
    logic [11:0] exp_dat [$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_pop(input logic [3:0] p, input logic [11:0] d, input bit pushed);
        exp_pop.push_back(p);
        if (pushed) exp_dat.push_back(d);
    endtask

    // Monitor
    initial begin
        logic [3:0]  ep;
        logic [11:0] ed;
        logic [1:0]  gi;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pop_signal != 4'b0) begin
                if (exp_pop.size() == 0) chk("pop_unexpected", {28'b0, bus.pop_signal}, 32'h0);
                else begin
                    ep = exp_pop.pop_front();
                    gi = 2'd0;
                    for (int k = 0; k < 4; k++) if (ep[k]) gi = 2'(k);
                    chk("pop", {28'b0, bus.pop_signal}, {28'b0, ep});
                    chk("grant", {30'b0, bus.grant}, {30'b0, gi});
                end
            end
            if (bus.push_out) begin
                if (bus.full_out) chk("overflow_push_while_full", 32'd1, 32'd0);
                if (exp_dat.size() == 0) chk("push_unexpected", {20'b0, bus.data_in}, 32'h0);
                else begin
                    ed = exp_dat.pop_front();
                    chk("push_data", {20'b0, bus.data_in}, {20'b0, ed});
                end
            end
        end
    end

    task automatic drain();
        bus.empty_f_signal = 4'b1111;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.empty_f_signal  = 4'b0000;
        bus.almost_full_out = 1'b0;
        bus.full_out        = 1'b0;
        state   = 4'b1000;
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pop", {28'b0, bus.pop_signal}, 32'h0);
        chk("rst_push", {31'b0, bus.push_out}, 32'h0);
        chk("rst_data", {20'b0, bus.data_in}, 32'h0);
        chk("rst_grant", {30'b0, bus.grant}, 32'h0);
        chk("rst_idle", {31'b0, bus.idle}, 32'h1);

        // All sources non-empty for 8 cycles
`ifdef STRICT_PRIORITY_EN
        for (int k = 0; k < 8; k++) expect_pop(4'b0001, 12'(k), 1'b1);
`else
        for (int k = 0; k < 8; k++)
            expect_pop(4'b0001 << (k % 4), 12'((k % 4) * 256 + k / 4), 1'b1);
`endif
        reset_L = 1'b1;
        repeat (8) @(negedge clk);
        chk("busy_idle", {31'b0, bus.idle}, 32'h0);
        drain();
        chk("drained_idle", {31'b0, bus.idle}, 32'h1);
        chk("drained_push", {31'b0, bus.push_out}, 32'h0);

        // Sparse sources
`ifdef STRICT_PRIORITY_EN
        expect_pop(4'b0001, 12'h008, 1'b1);
        expect_pop(4'b0001, 12'h009, 1'b1);
        expect_pop(4'b0001, 12'h00A, 1'b1);
        expect_pop(4'b0010, 12'h100, 1'b1);
        expect_pop(4'b0010, 12'h101, 1'b1);
        expect_pop(4'b0010, 12'h102, 1'b1);
        bus.empty_f_signal = 4'b1010;
        repeat (3) @(negedge clk);
        bus.empty_f_signal = 4'b0001;
        repeat (3) @(negedge clk);
`else
        expect_pop(4'b0001, 12'h002, 1'b1);
        expect_pop(4'b0100, 12'h202, 1'b1);
        expect_pop(4'b0001, 12'h003, 1'b1);
        expect_pop(4'b0010, 12'h102, 1'b1);
        expect_pop(4'b0100, 12'h203, 1'b1);
        expect_pop(4'b0001, 12'h004, 1'b1);
        bus.empty_f_signal = 4'b1010;
        repeat (3) @(negedge clk);
        bus.empty_f_signal = 4'b1000;
        repeat (3) @(negedge clk);
`endif
        drain();

        // Throttle: almost_full raised while a pop is on the bus
`ifdef STRICT_PRIORITY_EN
        expect_pop(4'b0001, 12'h00B, 1'b1);
        expect_pop(4'b0001, 12'h00C, 1'b1);
`else
        expect_pop(4'b0010, 12'h103, 1'b1);
        expect_pop(4'b0100, 12'h204, 1'b1);
`endif
        bus.empty_f_signal = 4'b0000;
        @(negedge clk);
        bus.almost_full_out = 1'b1;
        @(negedge clk);
        chk("af_push_inflight", {31'b0, bus.push_out}, 32'h1);
        chk("af_no_pop", {28'b0, bus.pop_signal}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("af_hold_no_pop", {28'b0, bus.pop_signal}, 32'h0);
        end
        bus.almost_full_out = 1'b0;
        @(negedge clk);
        drain();

        // State gating
        state = 4'b0001;
        bus.empty_f_signal = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            chk("state_reset_no_pop", {28'b0, bus.pop_signal}, 32'h0);
            chk("state_reset_no_push", {31'b0, bus.push_out}, 32'h0);
        end
`ifdef STRICT_PRIORITY_EN
        expect_pop(4'b0001, 12'h00D, 1'b1);
`else
        expect_pop(4'b1000, 12'h302, 1'b1);
`endif
        state = 4'b1000;
        @(negedge clk);
        state = 4'b0100;
        @(negedge clk);
        chk("leave_active_push", {31'b0, bus.push_out}, 32'h1);
        chk("leave_active_no_pop", {28'b0, bus.pop_signal}, 32'h0);
        @(negedge clk);
        chk("leave_active_silent", {31'b0, bus.push_out}, 32'h0);
        drain();

        // Reset with a line in flight: that line is dropped, rr restarts at 0
`ifdef STRICT_PRIORITY_EN
        expect_pop(4'b0001, 12'h00E, 1'b1);
        expect_pop(4'b0001, 12'h00F, 1'b0);
        expect_pop(4'b0001, 12'h010, 1'b1);
`else
        expect_pop(4'b0001, 12'h005, 1'b1);
        expect_pop(4'b0010, 12'h104, 1'b0);
        expect_pop(4'b0001, 12'h006, 1'b1);
`endif
        state = 4'b1000;
        bus.empty_f_signal = 4'b0000;
        repeat (2) @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        chk("midrst_no_push", {31'b0, bus.push_out}, 32'h0);
        @(negedge clk);
        chk("midrst_no_push2", {31'b0, bus.push_out}, 32'h0);
        chk("midrst_no_pop", {28'b0, bus.pop_signal}, 32'h0);
        reset_L = 1'b1;
        @(negedge clk);
        drain();
        chk("final_idle", {31'b0, bus.idle}, 32'h1);
        chk("pop_queue_drained", exp_pop.size(), 32'd0);
        chk("push_queue_drained", exp_dat.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/referee_2.md
Name: referee_2

Overview:
- Egress-side arbiter for the transaction layer: drains the four per-class output FIFOs (indices 0..3, selected upstream by data[9:8]) into a single downstream FIFO.
- Companion to the ingress referee, which pops one source and pushes into four destination FIFOs. This block pops four sources and pushes into one destination.
- Runs only while the main control FSM reports ACTIVE, and throttles on the downstream almost-full flag.

Parameters:
- LINE_SIZE, 12, width of one transaction line
- NUM_SRC, 4, number of source FIFOs; fixed at 4, not a free parameter

Ports:
- clk  input  1  clock
- reset_L  input  1  synchronous active-low reset
- state  input  4  main FSM state, one-hot: 1=RESET, 2=INIT, 4=IDLE, 8=ACTIVE
- empty_f_signal  input  4  empty flag of source FIFO i
- data_out  input  4*LINE_SIZE  read data of source FIFO i at bits [i*LINE_SIZE +: LINE_SIZE]; valid the cycle after pop
- almost_full_out  input  1  downstream FIFO almost-full
- full_out  input  1  downstream FIFO full
- pop_signal  output  4  one-hot pop to source FIFOs
- push_out  output  1  push strobe to downstream FIFO
- data_in  output  LINE_SIZE  line to downstream FIFO
- grant  output  2  index of the last popped source
- idle  output  1  no work pending and nothing in flight

Behaviour:
- Clock and reset: all outputs are registered. reset_L is sampled at posedge clk.
- Reset values (reset_L=0): pop_signal=0, push_out=0, data_in=0, grant=0, idle=1, internal round-robin pointer rr=0, inflight=0.
- Enable: arbitration happens only when state==8. Any other state value gives pop_signal=0. An in-flight line still completes its push one cycle later.
- Pop condition, evaluated per cycle: state==8, almost_full_out=0, full_out=0, and at least one empty_f_signal[i]=0.
- Source selection: first non-empty index searching rr, rr+1, ... mod 4.
  - Drive pop_signal=one-hot(sel), grant=sel, and set rr=sel+1 mod 4 (wraps 3->0).
  - If no pop this cycle, rr is unchanged.
- At most one pop per cycle. Back-to-back pops are allowed every cycle.
- Pipeline, fixed latency of 1:
  - The cycle after a pop, push_out=1 and data_in=data_out slice of the popped index (index held in an internal register).
  - With no pop in the previous cycle, push_out=0 and data_in holds its last value.
- Throttle:
  - almost_full_out=1 blocks new pops; an already-popped line is still pushed next cycle. almost_full is required to reserve at least 1 slot.
  - If full_out=1 while a line is in flight, the line is still pushed. Downstream overflow is a system error; the bench flags it.
- idle=1 when all empty_f_signal=1 and no pop was issued in the previous cycle. Otherwise idle=0.
- Empty flag rising in the same cycle as selection: the selection uses the current sampled flag. The FIFO owns pop-on-empty protection.
- Reset mid-operation (reset_L=0 with a line in flight): the in-flight line is dropped, no push occurs, and rr returns to 0.
- Leaving ACTIVE mid-stream: no new pop; a pending push completes; rr is retained.

Optional Feature:
- STRICT_PRIORITY_EN
  - Defined: fixed priority, lowest non-empty index wins (0 > 1 > 2 > 3). rr is neither used nor updated.
  - Undefined: round-robin as described above.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with all FIFOs non-empty and state=8 -> pop_signal=0, push_out=0, data_in=0, idle=1.
- Round-robin fairness: state=8, empty_f_signal=4'b0000 held for 8 cycles, FIFO i supplies 12'h100*i+k -> pop_signal sequence 0001, 0010, 0100, 1000, repeating. Each push_out follows its pop by 1 cycle with the matching line.
- Sparse sources: empty_f_signal=4'b1010, rr=0 -> pops 0001, 0100, 0001, ... Source 1 becomes non-empty after the pop of 2 -> the next pop is 1000? No: index 3 is still empty, so the next pop is 0001, then 0010.
- Throttle: almost_full_out raised the same cycle as a pop -> that line is pushed the next cycle, and no pop occurs until almost_full_out=0. The pop resumes at the stored rr.
- State gating and reset mid-stream:
  - state=1 -> no pops.
  - state 8->4 while a line is in flight -> exactly one push, then silence.
  - reset_L=0 while a line is in flight -> no push.
- STRICT_PRIORITY_EN build: empty_f_signal=4'b0000 held -> pop_signal=0001 every cycle. FIFO 0 marked empty -> 0010.
